// File: rtl/rv32i_types.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : rv32i_types (package)
// Description : Shared types for the memory-side cache arbiter: the
//               arbiter state encoding, the owner encoding, and the
//               round-robin grant helper.
// Revision    : 1.0  initial release
// ============================================================================
package rv32i_types;

    // Arbiter state. Two bits are needed for three states; the fourth
    // encoding is unreachable and is steered back to IDLE by the FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Which cache owns, or last owned, the memory port.
    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } arb_owner_t;

    // Returns 1 when the D-cache should be granted.
    // A lone requester always wins. When both caches request, the one
    // that was not served last wins.
    function automatic logic arb_pick_d(
        input logic       i_req,
        input logic       d_req,
        input arb_owner_t last
    );
        return d_req & (~i_req | (last == OWNER_I));
    endfunction

endpackage : rv32i_types
`default_nettype wire

// File: rtl/cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : cache_arbiter
// Description : Shares one line-wide physical memory port between an
//               I-cache (fills only) and a D-cache (fills and writebacks).
//               A three-state FSM (IDLE -> BUSY -> DONE) serves one line
//               transaction at a time. Simultaneous requests are granted
//               round-robin, starting with the D-cache after reset.
//
// Ports       :
//   clk             system clock, rising edge
//   rst             asynchronous reset, active low
//   i_pmem_read     I-cache fill request (held until i_pmem_resp)
//   i_pmem_address  I-cache line address
//   i_pmem_rdata    line returned to the I-cache (registered)
//   i_pmem_resp     one-cycle completion pulse to the I-cache
//   d_pmem_read     D-cache fill request (held until d_pmem_resp)
//   d_pmem_write    D-cache writeback request (held until d_pmem_resp)
//   d_pmem_address  D-cache line address
//   d_pmem_wdata    D-cache writeback line
//   d_pmem_rdata    line returned to the D-cache (registered)
//   d_pmem_resp     one-cycle completion pulse to the D-cache
//   pmem_read       memory read command (registered)
//   pmem_write      memory write command (registered)
//   pmem_address    memory line address (registered)
//   pmem_wdata      memory write line (registered)
//   pmem_rdata      memory read line
//   pmem_resp       memory completion, single cycle
//
// Revision    : 1.0  initial release
// ============================================================================
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    // I-cache side
    input  logic              i_pmem_read,
    input  logic [ADDR_W-1:0] i_pmem_address,
    output logic [LINE_W-1:0] i_pmem_rdata,
    output logic              i_pmem_resp,

    // D-cache side
    input  logic              d_pmem_read,
    input  logic              d_pmem_write,
    input  logic [ADDR_W-1:0] d_pmem_address,
    input  logic [LINE_W-1:0] d_pmem_wdata,
    output logic [LINE_W-1:0] d_pmem_rdata,
    output logic              d_pmem_resp,

    // Memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    arb_state_t        r_state;
    arb_owner_t        r_owner;      // owner of the transaction in flight
    arb_owner_t        r_last;       // most recently granted requester

    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    // ------------------------------------------------------------------
    // Request decode and arbitration
    // ------------------------------------------------------------------
    logic w_i_req;
    logic w_d_req;
    logic w_grant_d;

    assign w_i_req   = i_pmem_read;
    // A D-cache request is either a fill or a writeback.
    assign w_d_req   = d_pmem_read | d_pmem_write;
    assign w_grant_d = arb_pick_d(w_i_req, w_d_req, r_last);

    // ------------------------------------------------------------------
    // FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= IDLE;
            r_owner        <= OWNER_I;
            r_last         <= OWNER_I;   // so D wins the first contested grant
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    // pmem_resp is deliberately not looked at here.
                    if (w_i_req || w_d_req) begin
                        r_state <= BUSY;
                        if (w_grant_d) begin
                            r_owner        <= OWNER_D;
                            r_last         <= OWNER_D;
                            r_pmem_address <= d_pmem_address;
                            r_pmem_wdata   <= d_pmem_wdata;
                            // Read and write together is a writeback.
                            r_pmem_write   <= d_pmem_write;
                            r_pmem_read    <= ~d_pmem_write;
                        end else begin
                            r_owner        <= OWNER_I;
                            r_last         <= OWNER_I;
                            r_pmem_address <= i_pmem_address;
                            r_pmem_wdata   <= '0;
                            r_pmem_write   <= 1'b0;
                            r_pmem_read    <= 1'b1;
                        end
                    end
                end

                BUSY: begin
                    // Command is held unchanged until memory completes.
                    if (pmem_resp) begin
                        r_state      <= DONE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                        if (r_owner == OWNER_D) begin
                            r_d_rdata <= pmem_rdata;
                            r_d_resp  <= 1'b1;
                        end else begin
                            r_i_rdata <= pmem_rdata;
                            r_i_resp  <= 1'b1;
                        end
                    end
                end

                DONE: begin
                    // The owner drops its request on seeing resp, so no
                    // arbitration here: waiting requests go in the next IDLE.
                    r_state  <= IDLE;
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign i_pmem_rdata = r_i_rdata;
    assign i_pmem_resp  = r_i_resp;
    assign d_pmem_rdata = r_d_rdata;
    assign d_pmem_resp  = r_d_resp;

endmodule : cache_arbiter
`default_nettype wire

// File: tb/tb_cache_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_cache_arbiter
// Description : Directed self-checking bench for cache_arbiter with a
//               small memory responder and hand-computed expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_cache_arbiter;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk;
    logic              rst;
    logic              i_pmem_read;
    logic [ADDR_W-1:0] i_pmem_address;
    logic [LINE_W-1:0] i_pmem_rdata;
    logic              i_pmem_resp;
    logic              d_pmem_read;
    logic              d_pmem_write;
    logic [ADDR_W-1:0] d_pmem_address;
    logic [LINE_W-1:0] d_pmem_wdata;
    logic [LINE_W-1:0] d_pmem_rdata;
    logic              d_pmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int n_checks = 0;
    int n_errors = 0;

    cache_arbiter #(
        .LINE_W (LINE_W),
        .ADDR_W (ADDR_W)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] obs,
                         input logic [LINE_W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responder. Called at posedge+1 with a request pending or a
    // command already up. Holds pmem_resp during the lat-th command cycle,
    // then checks the DONE cycle and the following IDLE cycle. Drops the
    // served requester's request on seeing its resp.
    // who: bit0 = I resp seen in DONE, bit1 = D resp seen in DONE.
    task automatic serve(input int lat, input logic [LINE_W-1:0] line,
                         output int wait_c, output logic cmd_rd,
                         output logic cmd_wr, output logic [ADDR_W-1:0] cmd_addr,
                         output logic [LINE_W-1:0] cmd_wd, output logic [1:0] who);
        logic stable;
        wait_c   = 0;
        cmd_rd   = 1'b0;
        cmd_wr   = 1'b0;
        cmd_addr = '0;
        cmd_wd   = '0;
        who      = 2'b00;
        stable   = 1'b1;
        while (!(pmem_read || pmem_write) && wait_c < 20) begin
            tick();
            wait_c++;
        end
        check("cmd_seen", (wait_c < 20), 1);
        if (wait_c < 20) begin
            cmd_rd   = pmem_read;
            cmd_wr   = pmem_write;
            cmd_addr = pmem_address;
            cmd_wd   = pmem_wdata;
            for (int k = 1; k <= lat; k++) begin
                if (pmem_read !== cmd_rd || pmem_write !== cmd_wr ||
                    pmem_address !== cmd_addr || pmem_wdata !== cmd_wd ||
                    i_pmem_resp !== 1'b0 || d_pmem_resp !== 1'b0)
                    stable = 1'b0;
                if (k == lat) begin
                    pmem_resp  = 1'b1;
                    pmem_rdata = line;
                end
                tick();
            end
            pmem_resp  = 1'b0;
            pmem_rdata = ~line;
            check("cmd_stable", stable, 1);
            check("cmd_drop", {pmem_read, pmem_write}, 0);
            who = {d_pmem_resp, i_pmem_resp};
            if (i_pmem_resp) i_pmem_read = 1'b0;
            if (d_pmem_resp) begin
                d_pmem_read  = 1'b0;
                d_pmem_write = 1'b0;
            end
            tick();
            check("resp_one_cycle", {d_pmem_resp, i_pmem_resp}, 0);
            check("idle_no_cmd", {pmem_read, pmem_write}, 0);
        end
    endtask

    logic [LINE_W-1:0] exp_i_rd;
    logic [LINE_W-1:0] exp_d_rd;
    logic [LINE_W-1:0] line;
    logic [LINE_W-1:0] wd;
    int                wc;
    logic              c_rd;
    logic              c_wr;
    logic [ADDR_W-1:0] c_addr;
    logic [LINE_W-1:0] c_wd;
    logic [1:0]        who;
    logic [1:0]        exp_who;
    logic [ADDR_W-1:0] exp_addr;

    task automatic check_all_zero(input string tag);
        check({tag, "_cmd"},   {pmem_read, pmem_write}, 0);
        check({tag, "_addr"},  pmem_address, 0);
        check({tag, "_wdata"}, pmem_wdata, 0);
        check({tag, "_irdata"}, i_pmem_rdata, 0);
        check({tag, "_drdata"}, d_pmem_rdata, 0);
        check({tag, "_resp"},  {d_pmem_resp, i_pmem_resp}, 0);
    endtask

    initial begin
        rst            = 1'b0;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;
        pmem_rdata     = '0;
        pmem_resp      = 1'b0;
        exp_i_rd       = '0;
        exp_d_rd       = '0;

        tick();
        tick();
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        tick();

        // I-cache fill, 5-cycle memory latency.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0060;
        tick();
        check("i_cmd_latency", {pmem_read, pmem_write}, 2'b10);
        check("i_cmd_addr", pmem_address, 32'h0000_0060);
        line = {32{8'hA5}};
        serve(5, line, wc, c_rd, c_wr, c_addr, c_wd, who);
        exp_i_rd = line;
        check("i_wait", wc, 0);
        check("i_who", who, 2'b01);
        check("i_rdata", i_pmem_rdata, exp_i_rd);
        check("i_d_rdata_kept", d_pmem_rdata, exp_d_rd);

        // D-cache writeback.
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h1000_0040;
        wd             = {8{32'hDEADBEEF}};
        d_pmem_wdata   = wd;
        line = {8{32'h0BAD_F00D}};
        serve(3, line, wc, c_rd, c_wr, c_addr, c_wd, who);
        exp_d_rd = line;
        check("dw_wait", wc, 1);
        check("dw_cmd", {c_rd, c_wr}, 2'b01);
        check("dw_addr", c_addr, 32'h1000_0040);
        check("dw_wdata", c_wd, wd);
        check("dw_who", who, 2'b10);
        check("dw_rdata", d_pmem_rdata, exp_d_rd);
        check("dw_i_rdata_kept", i_pmem_rdata, exp_i_rd);

        // Spurious memory response while idle.
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h5555_AAAA}};
        tick();
        pmem_resp = 1'b0;
        check("spur_resp", {d_pmem_resp, i_pmem_resp}, 0);
        check("spur_cmd", {pmem_read, pmem_write}, 0);
        tick();
        check("spur_cmd2", {pmem_read, pmem_write}, 0);
        check("spur_irdata", i_pmem_rdata, exp_i_rd);
        check("spur_drdata", d_pmem_rdata, exp_d_rd);

        // Read and write together from D is a writeback; D was also the
        // last served, yet as the only requester it is granted.
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b1;
        d_pmem_address = 32'h2000_0080;
        wd             = {8{32'h1234_5678}};
        d_pmem_wdata   = wd;
        line = {8{32'hCAFE_0001}};
        serve(1, line, wc, c_rd, c_wr, c_addr, c_wd, who);
        exp_d_rd = line;
        check("rw_cmd", {c_rd, c_wr}, 2'b01);
        check("rw_addr", c_addr, 32'h2000_0080);
        check("rw_wdata", c_wd, wd);
        check("rw_who", who, 2'b10);

        // Reset two cycles into BUSY.
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0080;
        tick();
        check("abort_cmd_up", {pmem_read, pmem_write}, 2'b10);
        tick();
        tick();
        rst = 1'b0;
        #1;
        exp_i_rd = '0;
        exp_d_rd = '0;
        check_all_zero("abort");
        tick();
        check("abort_hold_resp", {d_pmem_resp, i_pmem_resp}, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_no_cmd", {pmem_read, pmem_write}, 0);
        check("abort_no_resp", {d_pmem_resp, i_pmem_resp}, 0);
        line = {8{32'h7777_0000}};
        serve(2, line, wc, c_rd, c_wr, c_addr, c_wd, who);
        exp_i_rd = line;
        check("abort_regrant_wait", wc, 1);
        check("abort_regrant_who", who, 2'b01);
        check("abort_regrant_addr", c_addr, 32'h0000_0080);

        // Fresh reset, then contested requests: D, I, D, I.
        rst = 1'b0;
        tick();
        @(negedge clk);
        rst = 1'b1;
        exp_i_rd = '0;
        exp_d_rd = '0;
        tick();
        i_pmem_read    = 1'b1;
        i_pmem_address = 32'h0000_0100;
        d_pmem_read    = 1'b1;
        d_pmem_write   = 1'b0;
        d_pmem_address = 32'h0000_0200;
        for (int t = 0; t < 4; t++) begin
            line = {8{32'hF000_0000 + 32'(t)}};
            serve(2 + t, line, wc, c_rd, c_wr, c_addr, c_wd, who);
            exp_who  = (t % 2 == 0) ? 2'b10 : 2'b01;
            exp_addr = (t % 2 == 0) ? 32'h0000_0200 : 32'h0000_0100;
            if (t % 2 == 0) exp_d_rd = line;
            else            exp_i_rd = line;
            check($sformatf("rr%0d_wait", t), wc, 1);
            check($sformatf("rr%0d_who", t), who, exp_who);
            check($sformatf("rr%0d_addr", t), c_addr, exp_addr);
            check($sformatf("rr%0d_cmd", t), {c_rd, c_wr}, 2'b10);
            check($sformatf("rr%0d_irdata", t), i_pmem_rdata, exp_i_rd);
            check($sformatf("rr%0d_drdata", t), d_pmem_rdata, exp_d_rd);
            // Re-raise the served requester so both contend again.
            if (t < 3) begin
                if (t % 2 == 0) d_pmem_read = 1'b1;
                else            i_pmem_read = 1'b1;
            end
        end
        i_pmem_read = 1'b0;
        d_pmem_read = 1'b0;
        tick();
        check("end_idle", {pmem_read, pmem_write}, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_cache_arbiter
`default_nettype wire

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning cache line width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning physical address width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, with ports named as below.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  asynchronous active-low reset.
REQ-006 i_pmem_read  input  1  I-cache line-fill request; held until i_pmem_resp.
REQ-007 i_pmem_address  input  ADDR_W  I-cache line address, line-aligned.
REQ-008 i_pmem_rdata  output  LINE_W  line returned to the I-cache.
REQ-009 i_pmem_resp  output  1  one-cycle completion pulse to the I-cache.
REQ-010 d_pmem_read, d_pmem_write  input  1 each  D-cache fill and writeback requests; held until d_pmem_resp.
REQ-011 d_pmem_address  input  ADDR_W  D-cache line address.
REQ-012 d_pmem_wdata  input  LINE_W  D-cache writeback line.
REQ-013 d_pmem_rdata  output  LINE_W  line returned to the D-cache.
REQ-014 d_pmem_resp  output  1  one-cycle completion pulse to the D-cache.
REQ-015 pmem_read, pmem_write  output  1 each  memory-side commands, driven from registers.
REQ-016 pmem_address  output  ADDR_W  registered memory address.
REQ-017 pmem_wdata  output  LINE_W  registered memory write line.
REQ-018 pmem_rdata  input  LINE_W  memory read line.
REQ-019 pmem_resp  input  1  memory completion; valid for one cycle.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-021 IDLE -> BUSY SHALL occur on any pending request. At the same edge the block latches:
- owner
- address
- wdata
- read/write command
REQ-022 The pmem command SHALL be asserted from the cycle after the grant edge, and held constant through BUSY.
REQ-023 BUSY -> DONE SHALL occur on pmem_resp. At that edge the block deasserts the pmem command, registers pmem_rdata into the owner's rdata, and sets the owner's resp.
REQ-024 In DONE, the owner's resp SHALL be high for exactly that one cycle; DONE -> IDLE is unconditional.
REQ-025 Requests arriving during BUSY or DONE SHALL wait and be arbitrated on the next IDLE cycle.
REQ-026 A simultaneous I and D request in IDLE SHALL be granted round-robin: the requester not served last wins. The last-served flag resets to I, so D wins first.
REQ-027 A single pending requester in IDLE SHALL be granted regardless of the last-served flag.
REQ-028 d_pmem_read and d_pmem_write both high SHALL be treated as a writeback (write precedence).
REQ-029 pmem_resp SHALL be ignored outside BUSY.
REQ-030 The non-owner's resp SHALL never assert, and its rdata SHALL retain its prior value.
REQ-031 Minimum transaction latency SHALL be: request seen at edge N, command from cycle N+1, pmem_resp in cycle M gives requester resp in cycle M+1, and IDLE in cycle M+2.

Reset
REQ-032 While rst=0, the block SHALL asynchronously force:
- state = IDLE
- all outputs (including pmem_address, pmem_wdata and both rdata) = 0
- last-served flag = I
REQ-033 Reset mid-BUSY SHALL abort the transaction with no resp to either cache, and no command in the first cycle after release.

Structure
REQ-034 arb_state_t (IDLE/BUSY/DONE) and the owner enum (I/D) SHALL live in the shared rv32i_types package.
REQ-035 LINE_W and ADDR_W SHALL be module parameters, not package constants.
REQ-036 The block SHALL be a single module, with no sub-module instances.

Verification
REQ-037 Scenario: I-read 0x0000_0060, memory responds after 5 cycles with line 0xA5 repeated -> pmem_read=1, pmem_address=0x60 for 5 cycles; i_pmem_rdata=0xA5 repeated; i_pmem_resp for 1 cycle.
REQ-038 Scenario: I and D read requested in the same cycle just after reset -> D served first; I granted in the IDLE cycle after D's DONE.
REQ-039 Scenario: D write 0x1000_0040 with wdata 0xDEADBEEF repeated -> pmem_write=1 with that address and data; pmem_read=0 throughout; d_pmem_resp for 1 cycle.
REQ-040 Scenario: back-to-back simultaneous requests for 4 transactions -> grant order D, I, D, I.
REQ-041 Scenario: rst=0 asserted 2 cycles into BUSY -> all outputs 0 immediately; no resp; IDLE after release.
REQ-042 Scenario: spurious pmem_resp in IDLE -> no state change and no resp.
